// File: rtl/acquisition_sequencer.sv
// Acquisition run sequencer: accepts START/STOP/SET_FRAMES commands, drives the
// readout enable, counts completed frames and bounds a graceful stop with a timeout.
module acquisition_sequencer #(
  parameter int unsigned INTG_SHIFT   = 2,
  parameter int unsigned DEFAULT_INTG = 5000,
  parameter int unsigned STOP_TIMEOUT = 1000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_word,
  output logic        cmd_ready,
  input  logic        frame_done,
  output logic        running,
  output logic [31:0] integration_clock_count,
  output logic [15:0] frame_count,
  output logic        stopping,
  output logic        cmd_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOOP       = 2'b00,
    OP_START      = 2'b01,
    OP_STOP       = 2'b10,
    OP_SET_FRAMES = 2'b11
  } op_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(STOP_TIMEOUT - 1);
  localparam logic [31:0] INTG_RESET   = 32'(DEFAULT_INTG);

  state_t      state, state_next;
  logic        running_next;
  logic [31:0] intg_next;
  logic [15:0] frame_count_next;
  logic [13:0] frame_limit, frame_limit_next;
  logic [31:0] stop_timer, stop_timer_next;
  logic        cmd_error_next;

  op_t         op;
  logic [13:0] val;
  logic        accept;
  logic [15:0] frame_count_inc;
  logic        limit_hit;

  assign op     = op_t'(cmd_word[15:14]);
  assign val    = cmd_word[13:0];
  assign accept = cmd_valid & cmd_ready;

  // Saturating increment; a limit of zero means run until stopped.
  assign frame_count_inc = (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;
  assign limit_hit       = (frame_limit != 14'd0) && (frame_count_inc == {2'b00, frame_limit});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      running                 <= 1'b0;
      integration_clock_count <= INTG_RESET;
      frame_count             <= 16'd0;
      frame_limit             <= 14'd0;
      stop_timer              <= 32'd0;
      cmd_error               <= 1'b0;
    end else begin
      state                   <= state_next;
      running                 <= running_next;
      integration_clock_count <= intg_next;
      frame_count             <= frame_count_next;
      frame_limit             <= frame_limit_next;
      stop_timer              <= stop_timer_next;
      cmd_error               <= cmd_error_next;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next       = state;
    running_next     = running;
    intg_next        = integration_clock_count;
    frame_count_next = frame_count;
    frame_limit_next = frame_limit;
    cmd_error_next   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_START: begin
              if (val != 14'd0) begin
                intg_next        = {18'b0, val} << INTG_SHIFT;
                frame_count_next = 16'd0;
                running_next     = 1'b1;
                state_next       = RUN;
              end else begin
                cmd_error_next = 1'b1;
              end
            end
            OP_SET_FRAMES: frame_limit_next = val;
            OP_STOP, OP_NOOP: ;
          endcase
        end
      end

      RUN: begin
        if (frame_done) frame_count_next = frame_count_inc;
        if (frame_done && limit_hit) begin
          // A limit-reaching frame wins over a simultaneous STOP.
          running_next = 1'b0;
          state_next   = IDLE;
        end else if (accept && op == OP_STOP) begin
          state_next = STOPPING;
        end
        if (accept && (op == OP_START || op == OP_SET_FRAMES)) cmd_error_next = 1'b1;
      end

      STOPPING: begin
        if (frame_done) begin
          frame_count_next = frame_count_inc;
          running_next     = 1'b0;
          state_next       = IDLE;
        end else if (stop_timer == TIMEOUT_LAST) begin
          running_next   = 1'b0;
          state_next     = IDLE;
          cmd_error_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    // Timer restarts from zero on every entry into STOPPING.
    stop_timer_next = 32'd0;
    if (state == STOPPING && state_next == STOPPING) stop_timer_next = stop_timer + 32'd1;
  end

  always_comb begin
    cmd_ready = (state != STOPPING);
    stopping  = (state == STOPPING);
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Scoreboard bench for acquisition_sequencer: stimulus queues expected output
// snapshots tagged with a cycle number; a monitor compares them at the falling edge.
module tb_acquisition_sequencer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        frame_done;
  logic        running;
  logic [31:0] integration_clock_count;
  logic [15:0] frame_count;
  logic        stopping;
  logic        cmd_error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [51:0] exp;
  } exp_t;

  exp_t q[$];

  acquisition_sequencer #(
    .INTG_SHIFT  (2),
    .DEFAULT_INTG(5000),
    .STOP_TIMEOUT(16)
  ) dut (
    .clk_in                 (clk_in),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_word               (cmd_word),
    .cmd_ready              (cmd_ready),
    .frame_done             (frame_done),
    .running                (running),
    .integration_clock_count(integration_clock_count),
    .frame_count            (frame_count),
    .stopping               (stopping),
    .cmd_error              (cmd_error)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [51:0] snap();
    return {running, stopping, cmd_ready, cmd_error, frame_count, integration_clock_count};
  endfunction

  task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got run/stop/rdy/err=%b%b%b%b fc=%0d icc=%0d, expected run/stop/rdy/err=%b%b%b%b fc=%0d icc=%0d",
               name, act[51], act[50], act[49], act[48], act[47:32], act[31:0],
               exp[51], exp[50], exp[49], exp[48], exp[47:32], exp[31:0]);
    end
  endtask

  // Queue an expected snapshot d cycles from now.
  task automatic push(input int d, input string name, input logic r, input logic s,
                      input logic rdy, input logic e, input logic [15:0] fc, input logic [31:0] icc);
    exp_t x;
    x.cyc  = cyc + d;
    x.name = name;
    x.exp  = {r, s, rdy, e, fc, icc};
    q.push_back(x);
  endtask

  task automatic apply(input logic v, input logic [15:0] w, input logic fd);
    cmd_valid  = v;
    cmd_word   = w;
    frame_done = fd;
    @(negedge clk_in);
    cmd_valid  = 1'b0;
    cmd_word   = 16'h0000;
    frame_done = 1'b0;
  endtask

  // Monitor: compares every queued snapshot whose cycle has arrived.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_in);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        if (x.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: snapshot for cycle %0d missed at cycle %0d", x.name, x.cyc, cyc);
        end else begin
          check(x.name, snap(), x.exp);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_word   = 16'h0000;
    frame_done = 1'b0;
    #2;
    check("reset_state", snap(), {1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd5000});
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    // Start with 100 -> 400 clocks, then graceful stop.
    push(1, "start_100", 1, 0, 1, 0, 16'd0, 32'd400);         apply(1, 16'h4064, 0);
    push(1, "stop_enter", 1, 1, 0, 0, 16'd0, 32'd400);        apply(1, 16'h8000, 0);
    push(1, "stop_wait", 1, 1, 0, 0, 16'd0, 32'd400);         apply(0, 16'h0000, 0);
    push(1, "stop_frame", 0, 0, 1, 0, 16'd1, 32'd400);        apply(0, 16'h0000, 1);

    // Frame limit of 3.
    push(1, "set_frames_3", 0, 0, 1, 0, 16'd1, 32'd400);      apply(1, 16'hC003, 0);
    push(1, "limit_start", 1, 0, 1, 0, 16'd0, 32'd400);       apply(1, 16'h4064, 0);
    push(1, "limit_f1", 1, 0, 1, 0, 16'd1, 32'd400);          apply(0, 16'h0000, 1);
    push(1, "limit_f2", 1, 0, 1, 0, 16'd2, 32'd400);          apply(0, 16'h0000, 1);
    push(1, "limit_f3", 0, 0, 1, 0, 16'd3, 32'd400);          apply(0, 16'h0000, 1);
    push(1, "idle_frame_ignored", 0, 0, 1, 0, 16'd3, 32'd400); apply(0, 16'h0000, 1);

    // Error cases.
    push(1, "err_start0", 0, 0, 1, 1, 16'd3, 32'd400);        apply(1, 16'h4000, 0);
    push(1, "err_start0_end", 0, 0, 1, 0, 16'd3, 32'd400);    apply(0, 16'h0000, 0);
    push(1, "start_8", 1, 0, 1, 0, 16'd0, 32'd32);            apply(1, 16'h4008, 0);
    push(1, "err_start_in_run", 1, 0, 1, 1, 16'd0, 32'd32);   apply(1, 16'h4010, 0);
    push(1, "noop_in_run", 1, 0, 1, 0, 16'd0, 32'd32);        apply(1, 16'h0000, 0);
    push(1, "err_setf_in_run", 1, 0, 1, 1, 16'd0, 32'd32);    apply(1, 16'hC005, 0);
    push(1, "err_setf_end", 1, 0, 1, 0, 16'd0, 32'd32);       apply(0, 16'h0000, 0);

    // Collision: STOP with the limit-reaching frame (limit still 3).
    push(1, "coll_f1", 1, 0, 1, 0, 16'd1, 32'd32);            apply(0, 16'h0000, 1);
    push(1, "coll_f2", 1, 0, 1, 0, 16'd2, 32'd32);            apply(0, 16'h0000, 1);
    push(1, "coll_stop_limit", 0, 0, 1, 0, 16'd3, 32'd32);    apply(1, 16'h8000, 1);
    push(1, "coll_after", 0, 0, 1, 0, 16'd3, 32'd32);         apply(0, 16'h0000, 0);
    push(1, "stop_in_idle", 0, 0, 1, 0, 16'd3, 32'd32);       apply(1, 16'h8000, 0);

    // Continuous run, STOP with a non-limit frame, then stop timeout.
    push(1, "set_frames_0", 0, 0, 1, 0, 16'd3, 32'd32);       apply(1, 16'hC000, 0);
    push(1, "start_1", 1, 0, 1, 0, 16'd0, 32'd4);             apply(1, 16'h4001, 0);
    push(1, "stop_with_frame", 1, 1, 0, 0, 16'd1, 32'd4);     apply(1, 16'h8000, 1);
    push(8, "timeout_mid", 1, 1, 0, 0, 16'd1, 32'd4);
    push(15, "timeout_last", 1, 1, 0, 0, 16'd1, 32'd4);
    push(16, "timeout_fire", 0, 0, 1, 1, 16'd1, 32'd4);
    push(17, "timeout_pulse_end", 0, 0, 1, 0, 16'd1, 32'd4);
    repeat (17) apply(0, 16'h0000, 0);

    // Asynchronous reset mid-run.
    push(1, "start_5", 1, 0, 1, 0, 16'd0, 32'd20);            apply(1, 16'h4005, 0);
    push(1, "run_f1", 1, 0, 1, 0, 16'd1, 32'd20);             apply(0, 16'h0000, 1);
    #2 reset = 1'b1;
    #1 check("async_reset_mid_run", snap(), {1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd5000});
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    push(1, "post_reset_start", 1, 0, 1, 0, 16'd0, 32'd12);   apply(1, 16'h4003, 0);
    push(1, "post_reset_frame", 1, 0, 1, 0, 16'd1, 32'd12);   apply(0, 16'h0000, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk_in);
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: snapshot for cycle %0d never compared", x.name, x.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acquisition_sequencer.md
ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

Interface
REQ-001 The block SHALL have parameter INTG_SHIFT, default 2, the left shift applied to the START value to form the integration clock count.
REQ-002 The block SHALL have parameter DEFAULT_INTG, default 5000, the integration_clock_count value after reset.
REQ-003 The block SHALL have parameter STOP_TIMEOUT, default 1000000, the maximum number of cycles spent in STOPPING.
REQ-004 The block SHALL have port clk_in, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: cmd_word is valid this cycle.
REQ-007 The block SHALL have port cmd_word, input, 16 bits: [15:14] op, [13:0] val.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-009 The block SHALL have port frame_done, input, 1 bit: single-cycle pulse from the readout controller at the end of a frame.
REQ-010 The block SHALL have port running, output, 1 bit: readout enable to the readout controller.
REQ-011 The block SHALL have port integration_clock_count, output, 32 bits: the integration length in clk_in cycles.
REQ-012 The block SHALL have port frame_count, output, 16 bits: frames completed in the current or last run.
REQ-013 The block SHALL have port stopping, output, 1 bit: high while in state STOPPING.
REQ-014 The block SHALL have port cmd_error, output, 1 bit: one-cycle pulse when a command is rejected or a stop times out.

Function
REQ-015 Op encoding SHALL be: 00 NOOP, 01 START, 10 STOP, 11 SET_FRAMES.
REQ-016 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal (state != STOPPING) combinationally.
REQ-017 The state machine SHALL have states IDLE, RUN and STOPPING, held in registers.
REQ-018 IDLE + START with val!=0: integration_clock_count <= {18'b0,val}<<INTG_SHIFT, frame_count <= 0, running <= 1, next state RUN; all registered, visible one cycle after acceptance.
REQ-019 IDLE + START with val==0: cmd_error pulses, all other state unchanged.
REQ-020 SET_FRAMES in IDLE: internal 14-bit frame_limit <= val (0 = continuous); in RUN: cmd_error pulses, command ignored.
REQ-021 START in RUN: cmd_error pulses, command ignored.
REQ-022 STOP in IDLE and NOOP in any state SHALL have no effect and no error.
REQ-023 RUN + frame_done: frame_count increments, saturating at 16'hFFFF.
REQ-024 RUN: if frame_limit!=0 and the incremented frame_count equals frame_limit, then running <= 0 and next state IDLE.
REQ-025 RUN + STOP with no simultaneous limit-reaching frame_done: next state STOPPING; running stays 1 until the frame completes.
REQ-026 RUN, STOP accepted in the same cycle as a limit-reaching frame_done: the limit wins, next state IDLE, the STOP is consumed without error.
REQ-027 RUN, STOP accepted with a non-limit frame_done: frame_count increments and next state STOPPING.
REQ-028 STOPPING + frame_done: frame_count increments, running <= 0, next state IDLE.
REQ-029 STOPPING: a 32-bit timer counts cycles; when it reaches STOP_TIMEOUT-1 with no frame_done, running <= 0, next state IDLE, cmd_error pulses.
REQ-030 The STOPPING timer SHALL clear on entry to STOPPING.
REQ-031 frame_done in IDLE SHALL be ignored.
REQ-032 integration_clock_count SHALL hold its value across STOP and run end.

Reset
REQ-033 While reset=1, independent of clk_in: state IDLE, running 0, stopping 0, cmd_error 0, frame_count 0, frame_limit 0, stop timer 0, integration_clock_count DEFAULT_INTG.
REQ-034 Reset asserted mid-run or mid-stop SHALL abort immediately, with no frame_count update and no cmd_error.
REQ-035 cmd_ready SHALL be 1 during reset.

Verification
REQ-036 Start: cmd 16'h4064 accepted -> next cycle running=1, integration_clock_count=400, frame_count=0.
REQ-037 Frame limit: SET_FRAMES 3, START 100, three frame_done pulses -> frame_count=3, running falls on the cycle after the third pulse, state IDLE.
REQ-038 Graceful stop: STOP in RUN -> stopping=1, cmd_ready=0, running=1; frame_done -> running=0, frame_count+1.
REQ-039 Stop timeout: STOP_TIMEOUT=16, STOP with no frame_done -> IDLE and one cmd_error pulse exactly 16 cycles after entering STOPPING.
REQ-040 Errors: START 0 in IDLE, then START and SET_FRAMES in RUN -> three single-cycle cmd_error pulses, no state change.
REQ-041 Collision and reset: STOP with the limit-reaching frame_done -> IDLE, no error; reset pulse mid-RUN -> all outputs at REQ-033 values asynchronously.
